imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-side responder for the non-pipelined RiSC-16 `core`. It is the block that answers the core's `pc` with an `instruction` word. It holds a program RAM that is filled over a valid/ready load stream while the core is kept in reset. Once the last word is accepted, it releases the core to run. It replaces the bench-driven `inst_reg` path, so a fixed program can be executed and compared against the `simulator` reference model.

## Interface
Parameters:
- `p_INST_MEM_SIZE`, default 1024: number of 16-bit instruction words; power of two, at least 2.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pc` in 16: program counter from `core`.
- `instruction` out 16: instruction word for `pc`, driven to `core.instruction`.
- `ld_start` in 1: single-cycle pulse that starts or restarts a program load.
- `ld_valid` in 1: a load word is present on `ld_data`.
- `ld_data` in 16: load word.
- `ld_last` in 1: qualifies `ld_data` as the final word of the program.
- `ld_ready` out 1: block accepts a load word this cycle.
- `core_rst` out 1: reset to `core`; high whenever the core must not execute.
- `load_count` out 16: number of words accepted in the current or most recent load.
- `ld_error` out 1: the last load overflowed the memory.

## Operation
- States: `HALT`, `LOAD`, `RUN`, `ERR`. Reset enters `HALT`.
- Reset values: `load_count` = 0, `ld_error` = 0, `ld_ready` = 0, `core_rst` = 1. `instruction` = 16'h0000, because the count is 0.
- `ld_start` from any state:
  - next state `LOAD`, `load_count` cleared to 0, `ld_error` cleared.
  - Any `ld_valid` in that same cycle is ignored, not accepted.
- `LOAD`:
  - `ld_ready` = 1.
  - Handshake (`ld_valid && ld_ready && !ld_start`) writes `ld_data` to `mem[load_count]` and increments `load_count`.
  - Handshake with `ld_last` = 1: next state `RUN`.
  - Handshake without `ld_last` that takes `load_count` to `p_INST_MEM_SIZE`: next state `ERR`, `ld_error` = 1.
  - `ld_valid` low: no change; the stream may stall indefinitely.
- `RUN`:
  - `ld_ready` = 0 and `core_rst` = 0.
  - Memory is read-only; load inputs other than `ld_start` are ignored.
- `ERR` and `HALT`:
  - `ld_ready` = 0, `core_rst` = 1.
  - Only `ld_start` leaves these states.
- `core_rst` = (state != `RUN`), decoded from registered state with no combinational path from inputs.
- Read path, combinational:
  - `instruction` = `mem[pc]` when `pc < load_count` and `pc < p_INST_MEM_SIZE`; otherwise 16'h0000.
  - 16'h0000 decodes as `add r0,r0,r0`, i.e. a NOP.
  - No RAM clearing is needed. Stale words from a previous, longer load are never visible.
- Width rules:
  - Address = `pc[$clog2(p_INST_MEM_SIZE)-1:0]`, used only after the range check.
  - Comparisons are unsigned 16-bit.
- `rst` asserted mid-load or mid-run returns to `HALT` immediately. RAM contents are undefined afterwards but masked, because `load_count` = 0.

## Timing
- Write latency: one cycle. A word accepted at edge N is readable through `instruction` after edge N.
- Release: last word accepted at edge N → state `RUN` and `core_rst` = 0 after edge N. The core's first fetch is `pc` = 0.
- `ld_start` at edge N → `core_rst` = 1 after edge N. The core's next state update is suppressed from edge N+1.
- Read is zero-latency, which matches the core's single-cycle fetch/execute: `instruction` must settle within the same cycle as `pc`.
- Throughput: one word per cycle with `ld_valid` held high.

## Structure
- Shared package `risc16_pkg`:
  - `imem_state_t` enum (`HALT`, `LOAD`, `RUN`, `ERR`).
  - `NOP_INST` = 16'h0000.
  - `WORD_W` = 16.
- Sub-module `imem_ram`: synchronous write, asynchronous read, parameterised depth. It holds no control logic.
- `imem_loader` contains the FSM, the counter, range masking and handshake.

## Test plan
- Reset → `core_rst` = 1, `ld_ready` = 0, `load_count` = 0, `ld_error` = 0; `pc` = 5 gives `instruction` = 0000.
- Start, load 3 words back-to-back (`ld_last` on the 3rd) → `load_count` = 3, `core_rst` falls one cycle after the 3rd handshake; `pc` = 2 reads word 2; `pc` = 3 reads 0000.
- Load with `ld_valid` toggling every other cycle → only handshake cycles write; `load_count` counts valid cycles only.
- `p_INST_MEM_SIZE` = 4, send 4 words with no `ld_last` → `ld_error` = 1, state `ERR`, `core_rst` stays 1, `ld_ready` = 0; then `ld_start` clears `ld_error`.
- In `RUN` after a 10-word load, `ld_start` and then a 2-word reload → `core_rst` high during the reload; `pc` = 5 reads 0000, not the stale word.
- Drive `core` with a loaded program, e.g. `addi r1,r0,7; add r2,r1,r1` → registers match `simulator`: r1 = 7, r2 = 14, `pc` = 2 after two cycles.
- `ld_start` coincident with `ld_valid` → word not written, `load_count` = 0.

Source files
------------

// File: rtl/risc16_pkg.sv
// ----------------------------------------------------------------------------
// risc16_pkg
//   Shared definitions for the RiSC-16 instruction-side blocks.
//   - WORD_W       : instruction / data word width
//   - NOP_INST     : encoding of "add r0,r0,r0", returned for unloaded addresses
//   - imem_state_t : states of the instruction-memory loader
// ----------------------------------------------------------------------------
package risc16_pkg;

  localparam int          WORD_W   = 16;
  localparam logic [15:0] NOP_INST = 16'h0000;

  typedef enum logic [1:0] {
    HALT = 2'd0,  // idle after reset, core held in reset
    LOAD = 2'd1,  // accepting program words
    RUN  = 2'd2,  // program loaded, core released
    ERR  = 2'd3   // load overflowed the memory, core held in reset
  } imem_state_t;

  // True when a 16-bit address lies below both the loaded word count and the
  // physical depth. Both comparisons are unsigned; the depth is passed widened
  // to 17 bits so a 65536-deep memory is still representable.
  function automatic logic addr_visible(input logic [15:0] addr,
                                        input logic [15:0] count,
                                        input logic [16:0] depth);
    return (addr < count) && ({1'b0, addr} < depth);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// ----------------------------------------------------------------------------
// imem_ram
//   Program storage for the instruction responder. Synchronous write,
//   asynchronous (combinational) read so the core can fetch in the same cycle
//   it presents its pc. Pure storage: no reset, no control logic.
// Ports:
//   clk      in  : write clock
//   wr_en    in  : write strobe, sampled on the rising edge
//   wr_addr  in  : write address
//   wr_data  in  : write word
//   rd_addr  in  : read address
//   rd_data  out : word at rd_addr, combinational
// ----------------------------------------------------------------------------
module imem_ram
  import risc16_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Zero-latency read: the core is single-cycle, fetch and execute share a clock.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Instruction-side responder for the non-pipelined RiSC-16 core. A program
//   is streamed into an internal RAM over a valid/ready interface while the
//   core is held in reset; once the word flagged as last is accepted the core
//   is released and its pc is answered combinationally from the RAM.
// Ports:
//   clk         in  : clock, all state changes on the rising edge
//   rst         in  : asynchronous active-high reset
//   pc          in  : program counter from the core
//   instruction out : word at pc, or NOP when pc is outside the loaded range
//   ld_start    in  : single-cycle pulse, starts/restarts a load
//   ld_valid    in  : load word present on ld_data
//   ld_data     in  : load word
//   ld_last     in  : ld_data is the final program word
//   ld_ready    out : a load word is accepted this cycle when ld_valid is high
//   core_rst    out : reset to the core, low only while running
//   load_count  out : words accepted in the current or most recent load
//   ld_error    out : the last load overflowed the memory
// ----------------------------------------------------------------------------
module imem_loader
  import risc16_pkg::*;
#(
  parameter int p_INST_MEM_SIZE = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  output logic [WORD_W-1:0] instruction,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              core_rst,
  output logic [15:0]       load_count,
  output logic              ld_error
);

  localparam int          ADDR_W   = $clog2(p_INST_MEM_SIZE);
  localparam logic [16:0] MEM_SIZE = 17'(p_INST_MEM_SIZE);

  imem_state_t state_reg, state_next;
  logic [15:0] load_count_reg, load_count_next;
  logic        ld_error_reg, ld_error_next;

  logic        handshake;
  logic [16:0] count_inc;
  logic        count_full;
  logic        wr_en;
  logic [WORD_W-1:0] rd_data;

  // ld_start wins over a coincident word: the restart must begin from an
  // empty program, so that word is dropped rather than written at index 0.
  assign handshake  = (state_reg == LOAD) && ld_valid && !ld_start;

  // Increment computed one bit wider so the full-memory check is exact even
  // at the largest depth a 16-bit pc can address.
  assign count_inc  = {1'b0, load_count_reg} + 17'd1;
  assign count_full = (count_inc == MEM_SIZE);

  // ----------------------------------------------------------------------------
  // Next-state logic
  // ----------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    load_count_next = load_count_reg;
    ld_error_next   = ld_error_reg;

    if (ld_start) begin
      state_next      = LOAD;
      load_count_next = 16'd0;
      ld_error_next   = 1'b0;
    end else begin
      unique case (state_reg)
        LOAD: begin
          if (handshake) begin
            load_count_next = count_inc[15:0];
            // A last word that exactly fills the memory is a valid program,
            // so ld_last is checked before the overflow condition.
            if (ld_last) begin
              state_next = RUN;
            end else if (count_full) begin
              state_next    = ERR;
              ld_error_next = 1'b1;
            end
          end
        end
        RUN:     state_next = RUN;
        ERR:     state_next = ERR;
        HALT:    state_next = HALT;
        default: state_next = HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= HALT;
      load_count_reg <= 16'd0;
      ld_error_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      load_count_reg <= load_count_next;
      ld_error_reg   <= ld_error_next;
    end
  end

  // ----------------------------------------------------------------------------
  // Outputs decoded from registered state only
  // ----------------------------------------------------------------------------
  assign ld_ready   = (state_reg == LOAD);
  assign core_rst   = (state_reg != RUN);
  assign load_count = load_count_reg;
  assign ld_error   = ld_error_reg;

  // ----------------------------------------------------------------------------
  // Program RAM
  // ----------------------------------------------------------------------------
  // While in LOAD the count is always below the depth (reaching it leaves
  // LOAD), so the truncated write address never aliases.
  assign wr_en = handshake;

  imem_ram #(
    .DEPTH  (p_INST_MEM_SIZE),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (load_count_reg[ADDR_W-1:0]),
    .wr_data (ld_data),
    .rd_addr (pc[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // Range masking: words beyond the current load (including stale words left
  // by an earlier, longer load or undefined contents after reset) read as NOP.
  // The truncated address is only trusted once the full pc passes the check.
  assign instruction = addr_visible(pc, load_count_reg, MEM_SIZE) ? rd_data : NOP_INST;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//   Two instances share one input stream: a default-depth loader and a 4-word
//   loader that overflows easily. A driver applies one input vector per cycle,
//   advances a behavioural model of each instance and queues the expected
//   outputs; a monitor on the falling edge pops and compares them.
// ----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int BIG_SIZE   = 1024;
  localparam int SMALL_SIZE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        ld_start, ld_valid, ld_last;
  logic [15:0] ld_data;

  logic [15:0] instruction_b, load_count_b, instruction_s, load_count_s;
  logic        ld_ready_b, core_rst_b, ld_error_b;
  logic        ld_ready_s, core_rst_s, ld_error_s;

  always #5 clk = ~clk;

  imem_loader #(.p_INST_MEM_SIZE(BIG_SIZE)) dut_big (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction_b),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready_b), .core_rst(core_rst_b), .load_count(load_count_b),
    .ld_error(ld_error_b)
  );

  imem_loader #(.p_INST_MEM_SIZE(SMALL_SIZE)) dut_small (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction_s),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready_s), .core_rst(core_rst_s), .load_count(load_count_s),
    .ld_error(ld_error_s)
  );

  // ---------------- reference model (one slot per instance) ----------------
  int          m_size    [2];
  logic [15:0] m_mem     [2][BIG_SIZE];
  int          m_count   [2];
  bit          m_loading [2];
  bit          m_running [2];
  bit          m_err     [2];

  typedef struct {
    int          dut;
    int          cyc;
    logic        core_rst;
    logic        ld_ready;
    logic        ld_error;
    logic [15:0] load_count;
    logic [15:0] instruction;
  } exp_t;

  exp_t q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cycle_no    = 0;

  // Inputs present during the cycle that ends at the next rising edge.
  logic        p_rst, p_start, p_valid, p_last;
  logic [15:0] p_data;

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_count[d]   = 0;
      m_loading[d] = 0;
      m_running[d] = 0;
      m_err[d]     = 0;
    end
  endfunction

  // Effect of one rising edge, from the load rules.
  function automatic void model_edge(input logic s, v, input logic [15:0] data, input logic last);
    for (int d = 0; d < 2; d++) begin
      if (s) begin
        m_loading[d] = 1; m_running[d] = 0; m_err[d] = 0; m_count[d] = 0;
      end else if (m_loading[d] && v) begin
        m_mem[d][m_count[d]] = data;
        m_count[d]++;
        if (last) begin
          m_loading[d] = 0; m_running[d] = 1;
        end else if (m_count[d] == m_size[d]) begin
          m_loading[d] = 0; m_err[d] = 1;
        end
      end
    end
  endfunction

  function automatic void push_expect(input logic [15:0] p);
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      e.dut         = d;
      e.cyc         = cycle_no;
      e.core_rst    = !m_running[d];
      e.ld_ready    = m_loading[d];
      e.ld_error    = m_err[d];
      e.load_count  = 16'(m_count[d]);
      e.instruction = (int'(p) < m_count[d] && int'(p) < m_size[d]) ? m_mem[d][p] : 16'h0000;
      q.push_back(e);
    end
  endfunction

  // One cycle: commit the previous inputs through the model, then drive new
  // inputs (reset acts on the model at once since it is asynchronous).
  task automatic cyc(input logic r, s, v, input logic [15:0] d, input logic l,
                     input logic [15:0] p);
    @(posedge clk);
    #1;
    cycle_no++;
    if (!p_rst) model_edge(p_start, p_valid, p_data, p_last);
    rst = r; ld_start = s; ld_valid = v; ld_data = d; ld_last = l; pc = p;
    if (r) model_reset();
    p_rst = r; p_start = s; p_valid = v; p_data = d; p_last = l;
    push_expect(p);
  endtask

  task automatic idle(input logic [15:0] p);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, p);
  endtask

  task automatic start();
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd0);
  endtask

  // ---------------- comparison ----------------
  task automatic chk(input string name, input int d, input int c,
                     input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut=%s cycle=%0d got=%h expected=%h",
               name, (d == 0) ? "big" : "small", c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.dut == 0) begin
        chk("core_rst",    0, e.cyc, {15'd0, core_rst_b}, {15'd0, e.core_rst});
        chk("ld_ready",    0, e.cyc, {15'd0, ld_ready_b}, {15'd0, e.ld_ready});
        chk("ld_error",    0, e.cyc, {15'd0, ld_error_b}, {15'd0, e.ld_error});
        chk("load_count",  0, e.cyc, load_count_b,        e.load_count);
        chk("instruction", 0, e.cyc, instruction_b,       e.instruction);
      end else begin
        chk("core_rst",    1, e.cyc, {15'd0, core_rst_s}, {15'd0, e.core_rst});
        chk("ld_ready",    1, e.cyc, {15'd0, ld_ready_s}, {15'd0, e.ld_ready});
        chk("ld_error",    1, e.cyc, {15'd0, ld_error_s}, {15'd0, e.ld_error});
        chk("load_count",  1, e.cyc, load_count_s,        e.load_count);
        chk("instruction", 1, e.cyc, instruction_s,       e.instruction);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    m_size[0] = BIG_SIZE;
    m_size[1] = SMALL_SIZE;
    model_reset();
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 16'h0; ld_last = 1'b0; pc = 16'd5;
    p_rst = 1'b1; p_start = 1'b0; p_valid = 1'b0; p_data = 16'h0; p_last = 1'b0;

    // Reset state, pc=5 must read NOP.
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'd5);
    repeat (2) idle(16'd5);

    // Three words back-to-back, last on the third.
    start();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 16'hA000 + 16'(i), i == 2, 16'd0);
    for (int i = 0; i < 5; i++) idle(16'(i));

    // ld_valid toggling every other cycle.
    start();
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b0, (i % 2) == 0, 16'hB000 + 16'(i), i == 6, 16'(i % 4));
    for (int i = 0; i < 6; i++) idle(16'(i));

    // Four words without last: small instance overflows, big keeps loading.
    start();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 16'hC000 + 16'(i), 1'b0, 16'(i));
    repeat (2) idle(16'd1);
    cyc(1'b0, 1'b0, 1'b1, 16'hC0FF, 1'b1, 16'd4);
    idle(16'd4);
    start();   // clears ld_error
    idle(16'd0);

    // Ten-word program, run, then restart with a two-word reload.
    start();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 16'hD000 + 16'(i), i == 9, 16'd5);
    repeat (2) idle(16'd5);
    start();
    cyc(1'b0, 1'b0, 1'b1, 16'hE000, 1'b0, 16'd5);
    cyc(1'b0, 1'b0, 1'b1, 16'hE001, 1'b1, 16'd5);
    for (int i = 0; i < 7; i++) idle(16'(i));

    // ld_start coincident with ld_valid: the word is dropped.
    cyc(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 16'd0);
    repeat (2) idle(16'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'd0);
    idle(16'd0);

    // Reset while running, then recovery.
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'd0);
    idle(16'd0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      logic        r, s, v, l;
      logic [15:0] d, p;
      r = ($urandom_range(0, 399) == 0);
      s = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 2) != 0);
      l = ($urandom_range(0, 11) == 0);
      d = 16'($urandom);
      p = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      cyc(r, s, v, d, l, p);
    end

    repeat (2) idle(16'd0);
    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
